l4_bt_coord: RTL and testbench
==============================

Name: l4_bt_coord

Overview:
- Three-axis backtrace position tracker for the L4 maze router. It replaces the single-axis up/down counter with X, Y and layer (Z) counters driven by direction-coded step commands over a valid/ready handshake.
- Adds bounds checking with a wrap or error mode, target detection, a path-length counter, and a small control FSM.
- Sits between the backtrace controller, which issues steps, and the grid address generator, which consumes x/y/z.

Parameters:
- XBITS, 5, width of X coordinate
- YBITS, 5, width of Y coordinate
- ZBITS, 1, width of layer coordinate
- XMAX, 31, largest legal X (must be <= 2^XBITS-1)
- YMAX, 31, largest legal Y
- ZMAX, 1, largest legal Z
- LBITS, 10, width of path-length counter
- WRAP, 0, 1 = out-of-bounds steps wrap (0<->MAX); 0 = out-of-bounds steps are errors

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high; overrides every other input
- ld  in  1  load start position and target, begin trace
- ld_x / ld_y / ld_z  in  XBITS / YBITS / ZBITS  start position
- tgt_x / tgt_y / tgt_z  in  XBITS / YBITS / ZBITS  target position, captured on ld
- step_valid  in  1  step command present
- step_dir  in  3  0=E(x+1) 1=W(x-1) 2=N(y+1) 3=S(y-1) 4=U(z+1) 5=D(z-1) 6,7=reserved
- step_ready  out  1  block accepts a step this cycle
- x / y / z  out  XBITS / YBITS / ZBITS  current position (registered)
- len  out  LBITS  accepted-step count
- at_tgt  out  1  high in DONE state
- err  out  1  high in ERROR state
- busy  out  1  high in ACTIVE state

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: x=y=z=0, len=0, state=IDLE, step_ready=0, at_tgt=0, err=0, busy=0. Reset takes priority over ld and over steps.
- FSM states: IDLE, ACTIVE, DONE, ERROR. Encoding is defined in the package.
- ld (any state, reset low): x/y/z <= ld_*, the target register <= tgt_*, len <= 0.
  - Next state is DONE if ld_* == tgt_*, otherwise ACTIVE.
  - A step_valid in the same cycle is ignored (ld has priority).
- Handshake: step_ready = (state==ACTIVE) & ~ld, combinational from state and ld. A step is accepted when step_valid & step_ready.
  - step_dir and step_valid must be held until accepted.
  - In IDLE, DONE or ERROR, steps are not accepted and have no effect.
- Accepted step, legal: exactly one axis changes by ±1. Result is visible on x/y/z the next cycle (1-cycle latency). len increments and saturates at 2^LBITS-1.
  - If the new position == target, the next state is DONE, so at_tgt rises in the same cycle the final position appears.
- Boundary handling. Out of bounds means x==XMAX with E, x==0 with W, and the analogous cases for Y and Z.
  - WRAP=0: position and len are unchanged, next state is ERROR.
  - WRAP=1: the axis wraps (MAX -> 0, 0 -> MAX), len increments, target check applies.
  - Reserved step_dir (6, 7) goes to ERROR regardless of WRAP, with no position change.
- Wrap is to MAX, not to 2^BITS-1, when MAX < 2^BITS-1.
- DONE and ERROR hold until ld or reset. Outputs stay frozen; err and at_tgt are never high together.
- Reset mid-trace: all state clears on the next edge. A pending step is dropped.
- Out-of-range ld values (ld_x > XMAX, etc.) are undefined usage. The bench must not drive them; no checking is required.

Decomposition:
- Package l4_coord_pkg holds:
  - direction code constants DIR_E..DIR_D;
  - state encoding ST_IDLE, ST_ACTIVE, ST_DONE, ST_ERROR;
  - the step_dir width constant.
- Sub-module l4_axis_counter, with parameters BITS, MAX and WRAP:
  - Inputs: clk, reset, ld, d, inc, dec.
  - Outputs: q, and comb flags at_max and at_min.
  - Instantiated three times. The top level decides legality from the flags and gates inc/dec.

Test Plan:
- Reset, then ld start (3,4,0), target (5,4,0). Steps E, E, each accepted with step_ready=1 -> x=4, then x=5; at_tgt=1 on the cycle x=5 appears; len=2; step_ready=0 afterwards.
- WRAP=0, ld (31,0,0), target (0,0,0), step E -> err=1, x stays 31, len=0. A further step_valid is not accepted. ld (1,0,0) clears err and sets busy.
- WRAP=1, XMAX=20: ld (20,2,1), target (0,2,1), step E -> x=0, at_tgt=1, len=1. Separately, ld (0,2,1), step W -> x=20.
- ld and step_valid asserted in the same cycle -> load wins; position equals ld_*, len=0, and the step is not consumed (step_ready=0 that cycle).
- step_dir=6 in ACTIVE -> ERROR with no movement. Then U at z=1 with ZMAX=1, WRAP=0 after a fresh ld -> ERROR.
- LBITS=3: 9 legal steps alternating E/W with a distant target -> len saturates at 7. Assert reset mid-sequence -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/l4_bt_coord_pkg.sv
// l4_bt_coord: shared constants and types for the backtrace tracker.
// Direction codes, FSM encoding and handshake widths.
package l4_coord_pkg;

  localparam int DIRW = 3;

  localparam logic [DIRW-1:0] DIR_E = 3'd0;
  localparam logic [DIRW-1:0] DIR_W = 3'd1;
  localparam logic [DIRW-1:0] DIR_N = 3'd2;
  localparam logic [DIRW-1:0] DIR_S = 3'd3;
  localparam logic [DIRW-1:0] DIR_U = 3'd4;
  localparam logic [DIRW-1:0] DIR_D = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/l4_bt_coord_if.sv
// l4_bt_coord: step command handshake between
// the backtrace controller and the tracker.
interface l4_bt_coord_if;
  import l4_coord_pkg::*;

  logic            step_valid;
  logic [DIRW-1:0] step_dir;
  logic            step_ready;

  modport master (
    output step_valid,
    output step_dir,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  step_dir,
    output step_ready
  );

endinterface

// File: rtl/l4_bt_coord_axis.sv
// l4_bt_coord: one coordinate axis with load,
// +/-1 stepping and optional wrap at 0 / MAX.
module l4_axis_counter #(
  parameter int BITS = 5,
  parameter int MAX  = 31,
  parameter bit WRAP = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [BITS-1:0] d,
  input  logic            inc,
  input  logic            dec,
  output logic [BITS-1:0] q,
  output logic            at_max,
  output logic            at_min
);

  localparam logic [BITS-1:0] QMAX = BITS'(MAX);

  assign at_max = (q == QMAX);
  assign at_min = (q == '0);

  // the parent never requests an overflowing move unless WRAP is set
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (inc) begin
      q <= (WRAP && at_max) ? '0 : q + 1'b1;
    end else if (dec) begin
      q <= (WRAP && at_min) ? QMAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/l4_bt_coord.sv
// l4_bt_coord: three-axis backtrace position tracker
// with bounds check, target detect and path length.
module l4_bt_coord
  import l4_coord_pkg::*;
#(
  parameter int XBITS = 5,
  parameter int YBITS = 5,
  parameter int ZBITS = 1,
  parameter int XMAX  = 31,
  parameter int YMAX  = 31,
  parameter int ZMAX  = 1,
  parameter int LBITS = 10,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [XBITS-1:0] ld_x,
  input  logic [YBITS-1:0] ld_y,
  input  logic [ZBITS-1:0] ld_z,
  input  logic [XBITS-1:0] tgt_x,
  input  logic [YBITS-1:0] tgt_y,
  input  logic [ZBITS-1:0] tgt_z,
  l4_bt_coord_if.slave     step,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic [ZBITS-1:0] z,
  output logic [LBITS-1:0] len,
  output logic             at_tgt,
  output logic             err,
  output logic             busy
);

  localparam logic [XBITS-1:0] XM = XBITS'(XMAX);
  localparam logic [YBITS-1:0] YM = YBITS'(YMAX);
  localparam logic [ZBITS-1:0] ZM = ZBITS'(ZMAX);

  state_t state_q, state_d;

  logic [XBITS-1:0] tx;
  logic [YBITS-1:0] ty;
  logic [ZBITS-1:0] tz;

  logic [7:0] dir_oh;
  logic       ready;
  logic       acc;
  logic       rsvd;
  logic       oob;
  logic       move;
  logic       go_err;
  logic       hit;
  logic       ld_hit;

  logic ix, dx, iy, dy, iz, dz;
  logic xmax_f, xmin_f;
  logic ymax_f, ymin_f;
  logic zmax_f, zmin_f;

  logic [XBITS-1:0] nx;
  logic [YBITS-1:0] ny;
  logic [ZBITS-1:0] nz;

  assign step.step_ready = ready;
  assign acc    = step.step_valid & ready;
  assign dir_oh = 8'd1 << step.step_dir;

  always_comb begin
    ix   = 1'b0;
    dx   = 1'b0;
    iy   = 1'b0;
    dy   = 1'b0;
    iz   = 1'b0;
    dz   = 1'b0;
    rsvd = 1'b0;
    oob  = 1'b0;
    unique case (1'b1)
      dir_oh[DIR_E]: begin
        ix  = 1'b1;
        oob = xmax_f;
      end
      dir_oh[DIR_W]: begin
        dx  = 1'b1;
        oob = xmin_f;
      end
      dir_oh[DIR_N]: begin
        iy  = 1'b1;
        oob = ymax_f;
      end
      dir_oh[DIR_S]: begin
        dy  = 1'b1;
        oob = ymin_f;
      end
      dir_oh[DIR_U]: begin
        iz  = 1'b1;
        oob = zmax_f;
      end
      dir_oh[DIR_D]: begin
        dz  = 1'b1;
        oob = zmin_f;
      end
      dir_oh[6]: rsvd = 1'b1;
      dir_oh[7]: rsvd = 1'b1;
      default:   rsvd = 1'b1;
    endcase
  end

  // a move happens only for a legal or wrapping accepted step
  assign move   = acc & ~rsvd & (~oob | WRAP);
  assign go_err = acc & (rsvd | (oob & ~WRAP));

  always_comb begin
    nx = x;
    ny = y;
    nz = z;
    if (ix) begin
      nx = xmax_f ? '0 : x + 1'b1;
    end else if (dx) begin
      nx = xmin_f ? XM : x - 1'b1;
    end
    if (iy) begin
      ny = ymax_f ? '0 : y + 1'b1;
    end else if (dy) begin
      ny = ymin_f ? YM : y - 1'b1;
    end
    if (iz) begin
      nz = zmax_f ? '0 : z + 1'b1;
    end else if (dz) begin
      nz = zmin_f ? ZM : z - 1'b1;
    end
  end

  assign hit    = (nx == tx) && (ny == ty) && (nz == tz);
  assign ld_hit = (ld_x == tgt_x) && (ld_y == tgt_y)
               && (ld_z == tgt_z);

  l4_axis_counter #(
    .BITS (XBITS),
    .MAX  (XMAX),
    .WRAP (WRAP)
  ) u_x (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .d      (ld_x),
    .inc    (move & ix),
    .dec    (move & dx),
    .q      (x),
    .at_max (xmax_f),
    .at_min (xmin_f)
  );

  l4_axis_counter #(
    .BITS (YBITS),
    .MAX  (YMAX),
    .WRAP (WRAP)
  ) u_y (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .d      (ld_y),
    .inc    (move & iy),
    .dec    (move & dy),
    .q      (y),
    .at_max (ymax_f),
    .at_min (ymin_f)
  );

  l4_axis_counter #(
    .BITS (ZBITS),
    .MAX  (ZMAX),
    .WRAP (WRAP)
  ) u_z (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .d      (ld_z),
    .inc    (move & iz),
    .dec    (move & dz),
    .q      (z),
    .at_max (zmax_f),
    .at_min (zmin_f)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= '0;
      ty <= '0;
      tz <= '0;
    end else if (ld) begin
      tx <= tgt_x;
      ty <= tgt_y;
      tz <= tgt_z;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
    end else if (ld) begin
      len <= '0;
    end else if (move && (len != '1)) begin
      len <= len + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = ld_hit ? ST_DONE : ST_ACTIVE;
    end else if (go_err) begin
      state_d = ST_ERROR;
    end else if (move && hit) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    busy   = 1'b0;
    at_tgt = 1'b0;
    err    = 1'b0;
    ready  = 1'b0;
    unique case (state_q)
      ST_ACTIVE: begin
        busy  = 1'b1;
        ready = ~ld;
      end
      ST_DONE:  at_tgt = 1'b1;
      ST_ERROR: err    = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_l4_bt_coord.sv
// Directed bench for l4_bt_coord: a default
// instance (A) and a wrapping, short-len instance (B).
module tb_l4_bt_coord;
  import l4_coord_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_ld = 1'b0;
  logic [4:0] a_lx = '0, a_ly = '0;
  logic [0:0] a_lz = '0;
  logic [4:0] a_tx = '0, a_ty = '0;
  logic [0:0] a_tz = '0;
  logic [4:0] a_x, a_y;
  logic [0:0] a_z;
  logic [9:0] a_len;
  logic       a_tgt, a_err, a_busy;

  logic       b_ld = 1'b0;
  logic [4:0] b_lx = '0, b_ly = '0;
  logic [0:0] b_lz = '0;
  logic [4:0] b_tx = '0, b_ty = '0;
  logic [0:0] b_tz = '0;
  logic [4:0] b_x, b_y;
  logic [0:0] b_z;
  logic [2:0] b_len;
  logic       b_tgt, b_err, b_busy;

  l4_bt_coord_if ia ();
  l4_bt_coord_if ib ();

  l4_bt_coord dut_a (
    .clk    (clk),
    .reset  (reset),
    .ld     (a_ld),
    .ld_x   (a_lx),
    .ld_y   (a_ly),
    .ld_z   (a_lz),
    .tgt_x  (a_tx),
    .tgt_y  (a_ty),
    .tgt_z  (a_tz),
    .step   (ia),
    .x      (a_x),
    .y      (a_y),
    .z      (a_z),
    .len    (a_len),
    .at_tgt (a_tgt),
    .err    (a_err),
    .busy   (a_busy)
  );

  l4_bt_coord #(
    .XMAX  (20),
    .LBITS (3),
    .WRAP  (1'b1)
  ) dut_b (
    .clk    (clk),
    .reset  (reset),
    .ld     (b_ld),
    .ld_x   (b_lx),
    .ld_y   (b_ly),
    .ld_z   (b_lz),
    .tgt_x  (b_tx),
    .tgt_y  (b_ty),
    .tgt_z  (b_tz),
    .step   (ib),
    .x      (b_x),
    .y      (b_y),
    .z      (b_z),
    .len    (b_len),
    .at_tgt (b_tgt),
    .err    (b_err),
    .busy   (b_busy)
  );

  initial begin
    ia.step_valid = 1'b0;
    ia.step_dir   = '0;
    ib.step_valid = 1'b0;
    ib.step_dir   = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [4:0] lx, ly,
                        input logic lz,
                        input logic [4:0] tx, ty,
                        input logic tz);
    a_ld = 1'b1;
    a_lx = lx; a_ly = ly; a_lz = lz;
    a_tx = tx; a_ty = ty; a_tz = tz;
    tick();
    a_ld = 1'b0;
  endtask

  task automatic load_b(input logic [4:0] lx, ly,
                        input logic lz,
                        input logic [4:0] tx, ty,
                        input logic tz);
    b_ld = 1'b1;
    b_lx = lx; b_ly = ly; b_lz = lz;
    b_tx = tx; b_ty = ty; b_tz = tz;
    tick();
    b_ld = 1'b0;
  endtask

  task automatic step_a(input logic [2:0] d);
    ia.step_valid = 1'b1;
    ia.step_dir   = d;
    tick();
    ia.step_valid = 1'b0;
  endtask

  task automatic step_b(input logic [2:0] d);
    ib.step_valid = 1'b1;
    ib.step_dir   = d;
    tick();
    ib.step_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({a_x, a_y, a_z, a_len} !== 21'd0) begin
      errors++;
      $display("FAIL reset_a_pos: got %h want 0",
               {a_x, a_y, a_z, a_len});
    end
    checks++;
    if ({a_busy, a_tgt, a_err, ia.step_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_a_flags: got %b want 0000",
               {a_busy, a_tgt, a_err, ia.step_ready});
    end
    checks++;
    if ({b_x, b_y, b_z, b_len, b_busy, b_tgt, b_err}
        !== 17'd0) begin
      errors++;
      $display("FAIL reset_b: got %h want 0",
               {b_x, b_y, b_z, b_len, b_busy, b_tgt, b_err});
    end
  endtask

  task automatic test_reach_target();
    load_a(5'd3, 5'd4, 1'b0, 5'd5, 5'd4, 1'b0);
    ia.step_valid = 1'b1;
    ia.step_dir   = DIR_E;
    #1;
    checks++;
    if (ia.step_ready !== 1'b1) begin
      errors++;
      $display("FAIL reach_rdy1: got %b want 1", ia.step_ready);
    end
    tick();
    checks++;
    if ({a_x, a_len, a_tgt} !== {5'd4, 10'd1, 1'b0}) begin
      errors++;
      $display("FAIL reach_s1: x=%0d len=%0d tgt=%b want 4 1 0",
               a_x, a_len, a_tgt);
    end
    checks++;
    if (ia.step_ready !== 1'b1) begin
      errors++;
      $display("FAIL reach_rdy2: got %b want 1", ia.step_ready);
    end
    tick();
    checks++;
    if ({a_x, a_len, a_tgt, a_busy, a_err}
        !== {5'd5, 10'd2, 3'b100}) begin
      errors++;
      $display("FAIL reach_s2: x=%0d len=%0d tgt=%b busy=%b err=%b",
               a_x, a_len, a_tgt, a_busy, a_err);
    end
    checks++;
    if (ia.step_ready !== 1'b0) begin
      errors++;
      $display("FAIL reach_rdy3: got %b want 0", ia.step_ready);
    end
    ia.step_valid = 1'b0;
  endtask

  task automatic test_oob_error();
    load_a(5'd31, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    step_a(DIR_E);
    checks++;
    if ({a_x, a_len, a_err, a_tgt, a_busy}
        !== {5'd31, 10'd0, 3'b100}) begin
      errors++;
      $display("FAIL oob_err: x=%0d len=%0d err=%b tgt=%b busy=%b",
               a_x, a_len, a_err, a_tgt, a_busy);
    end
    ia.step_valid = 1'b1;
    ia.step_dir   = DIR_W;
    #1;
    checks++;
    if (ia.step_ready !== 1'b0) begin
      errors++;
      $display("FAIL oob_rdy: got %b want 0", ia.step_ready);
    end
    tick();
    ia.step_valid = 1'b0;
    checks++;
    if ({a_x, a_err} !== {5'd31, 1'b1}) begin
      errors++;
      $display("FAIL oob_hold: x=%0d err=%b want 31 1", a_x, a_err);
    end
    load_a(5'd1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checks++;
    if ({a_x, a_err, a_busy} !== {5'd1, 2'b01}) begin
      errors++;
      $display("FAIL oob_reload: x=%0d err=%b busy=%b want 1 0 1",
               a_x, a_err, a_busy);
    end
  endtask

  task automatic test_wrap();
    load_b(5'd20, 5'd2, 1'b1, 5'd0, 5'd2, 1'b1);
    step_b(DIR_E);
    checks++;
    if ({b_x, b_len, b_tgt, b_err} !== {5'd0, 3'd1, 2'b10}) begin
      errors++;
      $display("FAIL wrap_e: x=%0d len=%0d tgt=%b err=%b",
               b_x, b_len, b_tgt, b_err);
    end
    load_b(5'd0, 5'd2, 1'b1, 5'd5, 5'd5, 1'b0);
    step_b(DIR_W);
    checks++;
    if ({b_x, b_len, b_busy, b_err} !== {5'd20, 3'd1, 2'b10}) begin
      errors++;
      $display("FAIL wrap_w: x=%0d len=%0d busy=%b err=%b",
               b_x, b_len, b_busy, b_err);
    end
  endtask

  task automatic test_ld_priority();
    a_ld = 1'b1;
    a_lx = 5'd7; a_ly = 5'd8; a_lz = 1'b1;
    a_tx = 5'd9; a_ty = 5'd9; a_tz = 1'b1;
    ia.step_valid = 1'b1;
    ia.step_dir   = DIR_E;
    #1;
    checks++;
    if (ia.step_ready !== 1'b0) begin
      errors++;
      $display("FAIL ldpri_rdy: got %b want 0", ia.step_ready);
    end
    tick();
    a_ld = 1'b0;
    ia.step_valid = 1'b0;
    checks++;
    if ({a_x, a_y, a_z, a_len, a_busy}
        !== {5'd7, 5'd8, 1'b1, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL ldpri_pos: x=%0d y=%0d z=%0d len=%0d busy=%b",
               a_x, a_y, a_z, a_len, a_busy);
    end
  endtask

  task automatic test_reserved();
    step_a(3'd6);
    checks++;
    if ({a_x, a_y, a_z, a_err, a_tgt}
        !== {5'd7, 5'd8, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL rsvd: x=%0d y=%0d z=%0d err=%b tgt=%b",
               a_x, a_y, a_z, a_err, a_tgt);
    end
    load_a(5'd2, 5'd2, 1'b1, 5'd3, 5'd3, 1'b0);
    step_a(DIR_U);
    checks++;
    if ({a_z, a_len, a_err, a_busy} !== {1'b1, 10'd0, 2'b10}) begin
      errors++;
      $display("FAIL z_oob: z=%0d len=%0d err=%b busy=%b",
               a_z, a_len, a_err, a_busy);
    end
  endtask

  task automatic test_axes();
    load_a(5'd10, 5'd10, 1'b0, 5'd9, 5'd11, 1'b1);
    step_a(DIR_N);
    step_a(DIR_U);
    checks++;
    if ({a_x, a_y, a_z, a_busy} !== {5'd10, 5'd11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL axes_nu: x=%0d y=%0d z=%0d busy=%b",
               a_x, a_y, a_z, a_busy);
    end
    step_a(DIR_W);
    checks++;
    if ({a_x, a_len, a_tgt} !== {5'd9, 10'd3, 1'b1}) begin
      errors++;
      $display("FAIL axes_w: x=%0d len=%0d tgt=%b want 9 3 1",
               a_x, a_len, a_tgt);
    end
    load_a(5'd10, 5'd10, 1'b1, 5'd10, 5'd9, 1'b0);
    step_a(DIR_S);
    step_a(DIR_D);
    checks++;
    if ({a_y, a_z, a_len, a_tgt}
        !== {5'd9, 1'b0, 10'd2, 1'b1}) begin
      errors++;
      $display("FAIL axes_sd: y=%0d z=%0d len=%0d tgt=%b",
               a_y, a_z, a_len, a_tgt);
    end
  endtask

  task automatic test_back_to_back();
    load_b(5'd5, 5'd5, 1'b0, 5'd10, 5'd10, 1'b1);
    ib.step_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ib.step_dir = (i % 2 == 0) ? DIR_E : DIR_W;
      tick();
    end
    ib.step_valid = 1'b0;
    checks++;
    if ({b_x, b_len, b_busy} !== {5'd6, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL sat: x=%0d len=%0d busy=%b want 6 7 1",
               b_x, b_len, b_busy);
    end
    ib.step_valid = 1'b1;
    ib.step_dir   = DIR_E;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ib.step_valid = 1'b0;
    checks++;
    if ({b_x, b_y, b_z, b_len, b_busy, b_tgt, b_err, ib.step_ready}
        !== 18'd0) begin
      errors++;
      $display("FAIL midreset: got %h want 0",
               {b_x, b_y, b_z, b_len, b_busy, b_tgt, b_err,
                ib.step_ready});
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_reach_target();
    test_oob_error();
    test_wrap();
    test_ld_priority();
    test_reserved();
    test_axes();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
